pd_multicycle_sequencer: RTL and testbench
==========================================

# pd_multicycle_sequencer

Control FSM that sequences the single shared PD datapath (fetch, decode, register file, execute, data memory) one instruction at a time. It steps each instruction through its stages and handshakes with instruction and data memory. It drives the PC, IR and register-file write enables, and counts retired instructions. It sits beside `design_wrapper`'s datapath and is the only agent allowed to advance the PC.

## Interface
Parameters:
- `RETIRE_W`, 32, width of the retired-instruction counter
- `TIMEOUT_CYCLES`, 16, maximum memory wait cycles before error halt; 0 disables the timeout

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `run`  in  1  start/continue sequencing
- `imem_req`  out  1  instruction fetch request
- `imem_ready`  in  1  instruction word valid this cycle
- `d_opcode`  in  7  opcode from decode stage
- `e_br_taken`  in  1  branch resolution from execute
- `dmem_req`  out  1  data memory request
- `dmem_we`  out  1  data memory write (store)
- `dmem_ready`  in  1  data access complete this cycle
- `ir_we`  out  1  latch fetched instruction
- `f_pc_we`  out  1  update PC this cycle
- `pc_sel`  out  1  0: PC+4, 1: ALU/branch target
- `rf_we`  out  1  register-file write enable
- `state`  out  3  current FSM state encoding
- `halt`  out  1  sticky halted indication
- `err`  out  1  sticky error (illegal opcode or timeout)
- `retired`  out  `RETIRE_W`  retired-instruction count

## Operation
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, HALT=6. Values 7 and above are unreachable and recover to HALT with `err`=1.
- IDLE: moves to FETCH when `run`=1.
- FETCH:
  - `imem_req`=1 is held until `imem_ready`.
  - On ready: `ir_we`=1 for that cycle, then move to DECODE.
- DECODE: one cycle. Latches `d_opcode` into an internal class register.
  - SYSTEM (1110011): go to HALT, `err`=0.
  - Opcode not in {0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011}: go to HALT, `err`=1.
  - Otherwise: go to EXECUTE.
- EXECUTE: one cycle.
  - BRANCH: `f_pc_we`=1, `pc_sel`=`e_br_taken`, retire the instruction.
  - LOAD/STORE: go to MEMORY.
  - All other classes: go to WRITEBACK.
- MEMORY: `dmem_req`=1 is held, with `dmem_we`=1 for STORE. On `dmem_ready`:
  - STORE: `f_pc_we`=1, `pc_sel`=0, retire.
  - LOAD: go to WRITEBACK.
- WRITEBACK: `rf_we`=1, `f_pc_we`=1, retire. `pc_sel`=1 for JAL/JALR, 0 otherwise.
- After retire: next state is FETCH if `run`=1, else IDLE. Deasserting `run` never aborts an instruction in flight.
- Retire: `retired` increments by 1 and wraps modulo 2^`RETIRE_W`.
- Timeout counter:
  - Counts consecutive non-ready cycles in FETCH or MEMORY, and clears on state change.
  - When it reaches `TIMEOUT_CYCLES`, go to HALT with `err`=1.
  - If ready and timeout occur in the same cycle, ready wins.
- HALT: absorbing until reset. `halt`=1 and all enables and requests are 0.

## Timing
- Reset values: `state`=IDLE, `retired`=0, `halt`=0, `err`=0. All enables and requests are 0.
- Reset asserts asynchronously mid-instruction, with no partial PC or register-file write after assertion.
- Enables (`ir_we`, `f_pc_we`, `rf_we`) and requests are Moore/Mealy combinational from registered state. They are valid in the same cycle as the state and are single-cycle pulses per instruction.
- `imem_ready` may be high in the first FETCH cycle, giving a 1-cycle fetch.
- Zero-wait latency, fetch to retire inclusive:
  - ALU/LUI/AUIPC/JAL/JALR: 4 cycles
  - Branch: 3 cycles
  - Store: 4 cycles
  - Load: 5 cycles
- Each memory wait cycle adds 1 cycle.
- `halt` and `err` are registered and assert in the cycle after the decision.

## Structure
- Package `pd_ctrl_pkg`:
  - state enum (3-bit)
  - opcode localparams
  - instruction-class enum: ALU, LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, SYSTEM, ILLEGAL
- Sub-module `pd_opcode_classifier`: combinational, maps 7-bit opcode to class.
- The FSM, timeout counter and retire counter live in `pd_multicycle_sequencer`.

## Test plan
- `run`=1, zero-wait memory, opcode 0010011 → states 1,2,3,5,1. Expect `rf_we` and `f_pc_we` high in WRITEBACK, `pc_sel`=0, `retired`=1.
- Branch 1100011 with `e_br_taken`=1, then with 0 → `f_pc_we` in EXECUTE with `pc_sel`=1, then 0. `rf_we` never asserts; 3 cycles each.
- Load with `dmem_ready` delayed 3 cycles → `dmem_req` high 4 cycles, `dmem_we`=0, then WRITEBACK; 8 cycles total. Store → `dmem_we`=1, no `rf_we`.
- Opcode 1111111 → HALT, `err`=1. Opcode 1110011 → HALT, `err`=0. Both are sticky while `run` toggles.
- `imem_ready` held 0 with `TIMEOUT_CYCLES`=16 → HALT with `err`=1 after 16 FETCH cycles. Ready on the 16th cycle → no error.
- `run` dropped in EXECUTE → instruction retires, then IDLE. Reset in MEMORY → IDLE immediately with all outputs 0. `RETIRE_W`=4 with 17 instructions → `retired`=1.

Source files
------------

// File: rtl/pd_ctrl_pkg.sv
// Shared types and constants for the PD multicycle control path:
// FSM state encoding, RV32I base opcodes and the instruction classes
// that the sequencer steers on.
package pd_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEMORY    = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_HALT      = 3'd6
  } state_t;

  localparam int CLS_W = 4;

  typedef enum logic [CLS_W-1:0] {
    CLS_ALU     = 4'd0,
    CLS_LUI     = 4'd1,
    CLS_AUIPC   = 4'd2,
    CLS_JAL     = 4'd3,
    CLS_JALR    = 4'd4,
    CLS_BRANCH  = 4'd5,
    CLS_LOAD    = 4'd6,
    CLS_STORE   = 4'd7,
    CLS_SYSTEM  = 4'd8,
    CLS_ILLEGAL = 4'd9
  } cls_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Classes that need a data-memory access before they can retire
  function automatic logic cls_is_mem(input cls_t c);
    return (c == CLS_LOAD) || (c == CLS_STORE);
  endfunction

  // Classes whose next PC comes from the ALU target rather than PC+4
  function automatic logic cls_is_jump(input cls_t c);
    return (c == CLS_JAL) || (c == CLS_JALR);
  endfunction

endpackage

// File: rtl/pd_opcode_classifier.sv
// Pure combinational opcode decoder: maps the 7-bit major opcode onto the
// instruction class the sequencer uses to pick its path through the stages.
module pd_opcode_classifier
  import pd_ctrl_pkg::*;
(
  input  logic [6:0]       i_opcode,
  output logic [CLS_W-1:0] o_cls
);

  // Anything outside the supported base set decodes as ILLEGAL
  always_comb begin
    o_cls = CLS_ILLEGAL;
    case (i_opcode)
      OPC_OP_IMM: o_cls = CLS_ALU;
      OPC_OP:     o_cls = CLS_ALU;
      OPC_LUI:    o_cls = CLS_LUI;
      OPC_AUIPC:  o_cls = CLS_AUIPC;
      OPC_JAL:    o_cls = CLS_JAL;
      OPC_JALR:   o_cls = CLS_JALR;
      OPC_BRANCH: o_cls = CLS_BRANCH;
      OPC_LOAD:   o_cls = CLS_LOAD;
      OPC_STORE:  o_cls = CLS_STORE;
      OPC_SYSTEM: o_cls = CLS_SYSTEM;
      default:    o_cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/pd_multicycle_sequencer.sv
// Multicycle control FSM for the shared PD datapath. Walks one instruction
// at a time through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, handshakes with
// instruction and data memory, owns every PC update, counts retirements and
// halts (optionally with an error) on SYSTEM, illegal opcodes or a memory
// that stops answering.
module pd_multicycle_sequencer
  import pd_ctrl_pkg::*;
#(
  parameter int RETIRE_W       = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  output logic                imem_req,
  input  logic                imem_ready,
  input  logic [6:0]          d_opcode,
  input  logic                e_br_taken,
  output logic                dmem_req,
  output logic                dmem_we,
  input  logic                dmem_ready,
  output logic                ir_we,
  output logic                f_pc_we,
  output logic                pc_sel,
  output logic                rf_we,
  output logic [2:0]          state,
  output logic                halt,
  output logic                err,
  output logic [RETIRE_W-1:0] retired
);

  // The wait counter only has to hold values up to TIMEOUT_CYCLES-1: the
  // cycle that would reach TIMEOUT_CYCLES is the one that halts.
  localparam int               TMO_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit               TMO_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES - 1);

  state_t                r_state;
  cls_t                  r_cls;
  logic [TMO_W-1:0]      r_tmo;
  logic                  r_halt;
  logic                  r_err;
  logic [RETIRE_W-1:0]   r_retired;

  logic [CLS_W-1:0]      w_cls_raw;
  cls_t                  w_cls;
  logic                  w_wait;
  logic                  w_tmo_hit;
  logic                  w_retire;
  state_t                w_after_retire;

  pd_opcode_classifier u_classifier (
    .i_opcode (d_opcode),
    .o_cls    (w_cls_raw)
  );

  assign w_cls = cls_t'(w_cls_raw);

  // A memory wait cycle is any FETCH/MEMORY cycle without the matching ready;
  // ready arriving on the limit cycle suppresses the timeout.
  always_comb begin
    w_wait = ((r_state == ST_FETCH)  && !imem_ready) ||
             ((r_state == ST_MEMORY) && !dmem_ready);
    w_tmo_hit      = TMO_EN && w_wait && (r_tmo == TMO_LIMIT);
    w_after_retire = run ? ST_FETCH : ST_IDLE;
  end

  // Datapath enables and memory requests, decoded from the registered state
  // (plus the ready/branch inputs that qualify them) so they are valid in the
  // same cycle as the state they belong to.
  always_comb begin
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    f_pc_we  = 1'b0;
    pc_sel   = 1'b0;
    rf_we    = 1'b0;
    w_retire = 1'b0;
    case (r_state)
      ST_FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_ready;
      end
      ST_EXECUTE: begin
        if (r_cls == CLS_BRANCH) begin
          f_pc_we  = 1'b1;
          pc_sel   = e_br_taken;
          w_retire = 1'b1;
        end
      end
      ST_MEMORY: begin
        dmem_req = 1'b1;
        dmem_we  = (r_cls == CLS_STORE);
        if (dmem_ready && (r_cls == CLS_STORE)) begin
          f_pc_we  = 1'b1;
          w_retire = 1'b1;
        end
      end
      ST_WRITEBACK: begin
        rf_we    = 1'b1;
        f_pc_we  = 1'b1;
        pc_sel   = cls_is_jump(r_cls);
        w_retire = 1'b1;
      end
      default: ;
    endcase
  end

  // Sequencer FSM with its class, wait-timeout, status and retire registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_cls     <= CLS_ALU;
      r_tmo     <= '0;
      r_halt    <= 1'b0;
      r_err     <= 1'b0;
      r_retired <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (run) r_state <= ST_FETCH;
        end
        ST_FETCH: begin
          if (imem_ready) begin
            r_state <= ST_DECODE;
          end else if (w_tmo_hit) begin
            r_state <= ST_HALT;
            r_halt  <= 1'b1;
            r_err   <= 1'b1;
          end
        end
        ST_DECODE: begin
          r_cls <= w_cls;
          if (w_cls == CLS_SYSTEM) begin
            r_state <= ST_HALT;
            r_halt  <= 1'b1;
          end else if (w_cls == CLS_ILLEGAL) begin
            r_state <= ST_HALT;
            r_halt  <= 1'b1;
            r_err   <= 1'b1;
          end else begin
            r_state <= ST_EXECUTE;
          end
        end
        ST_EXECUTE: begin
          if (r_cls == CLS_BRANCH)      r_state <= w_after_retire;
          else if (cls_is_mem(r_cls))   r_state <= ST_MEMORY;
          else                          r_state <= ST_WRITEBACK;
        end
        ST_MEMORY: begin
          if (dmem_ready) begin
            r_state <= (r_cls == CLS_STORE) ? w_after_retire : ST_WRITEBACK;
          end else if (w_tmo_hit) begin
            r_state <= ST_HALT;
            r_halt  <= 1'b1;
            r_err   <= 1'b1;
          end
        end
        ST_WRITEBACK: begin
          r_state <= w_after_retire;
        end
        ST_HALT: begin
          r_state <= ST_HALT;
        end
        default: begin
          // Corrupted encoding: park in HALT and flag it
          r_state <= ST_HALT;
          r_halt  <= 1'b1;
          r_err   <= 1'b1;
        end
      endcase

      if (TMO_EN && w_wait && !w_tmo_hit) r_tmo <= r_tmo + TMO_W'(1);
      else                                r_tmo <= '0;

      if (w_retire) r_retired <= r_retired + RETIRE_W'(1);
    end
  end

  assign state   = r_state;
  assign halt    = r_halt;
  assign err     = r_err;
  assign retired = r_retired;

endmodule

// File: tb/tb_pd_multicycle_sequencer.sv
// Scoreboard bench for pd_multicycle_sequencer. A memory model feeds opcodes
// and ready timing from a program queue; the stimulus pushes hand-computed
// per-instruction expectations; a monitor observes each retire / halt event
// and compares it against the head of the expectation queue.
module tb_pd_multicycle_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       run = 1'b0;
  logic       imem_req;
  logic       imem_ready = 1'b0;
  logic [6:0] d_opcode = 7'h13;
  logic       e_br_taken = 1'b0;
  logic       dmem_req;
  logic       dmem_we;
  logic       dmem_ready = 1'b0;
  logic       ir_we;
  logic       f_pc_we;
  logic       pc_sel;
  logic       rf_we;
  logic [2:0] state;
  logic       halt;
  logic       err;
  logic [3:0] retired;

  pd_multicycle_sequencer #(.RETIRE_W(4), .TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .imem_req   (imem_req),
    .imem_ready (imem_ready),
    .d_opcode   (d_opcode),
    .e_br_taken (e_br_taken),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_ready (dmem_ready),
    .ir_we      (ir_we),
    .f_pc_we    (f_pc_we),
    .pc_sel     (pc_sel),
    .rf_we      (rf_we),
    .state      (state),
    .halt       (halt),
    .err        (err),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] op;
    logic       br;
    int         iw;   // non-ready fetch cycles before ready, -1 = never
    int         dw;   // non-ready data cycles before ready, -1 = never
  } prog_t;

  typedef struct {
    int         kind; // 0 retire, 1 halt
    logic       pc_sel;
    logic       rf;
    logic       dwe;
    int         dreq;
    int         lat;
    logic       err;
    logic [3:0] ret;
  } exp_t;

  prog_t      prog_q[$];
  exp_t       sb_q[$];
  int         n_chk = 0;
  int         n_fail = 0;
  logic [3:0] model_ret = 4'd0;
  logic [2:0] exp_trace [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic load(input logic [6:0] op, input logic br, input int iw, input int dw);
    prog_t p;
    p.op = op; p.br = br; p.iw = iw; p.dw = dw;
    prog_q.push_back(p);
  endtask

  task automatic exp_ret(input logic ps, input logic rf, input logic dwe, input int dreq, input int lat);
    exp_t e;
    e.kind = 0; e.pc_sel = ps; e.rf = rf; e.dwe = dwe; e.dreq = dreq;
    e.lat = lat; e.err = 1'b0; e.ret = model_ret;
    sb_q.push_back(e);
    model_ret = model_ret + 4'd1;
  endtask

  task automatic exp_halt(input logic er, input int lat);
    exp_t e;
    e.kind = 1; e.pc_sel = 1'b0; e.rf = 1'b0; e.dwe = 1'b0; e.dreq = 0;
    e.lat = lat; e.err = er; e.ret = model_ret;
    sb_q.push_back(e);
  endtask

  // Memory model: picks up the next program entry at each fetch start
  initial begin
    prog_t      cur;
    int         icnt;
    int         dcnt;
    logic [2:0] prev;
    cur.op = 7'h13; cur.br = 1'b0; cur.iw = -1; cur.dw = 0;
    icnt = 0; dcnt = 0; prev = 3'd0;
    forever begin
      @(posedge clk); #1;
      if (state == 3'd1 && prev != 3'd1) begin
        if (prog_q.size() > 0) cur = prog_q.pop_front();
        else begin cur.op = 7'h13; cur.br = 1'b0; cur.iw = -1; cur.dw = 0; end
        icnt = 0;
      end
      if (state == 3'd1) begin
        imem_ready = (cur.iw >= 0) && (icnt == cur.iw);
        icnt++;
      end else imem_ready = 1'b0;
      if (state == 3'd4) begin
        dmem_ready = (cur.dw >= 0) && (dcnt == cur.dw);
        dcnt++;
      end else begin
        dmem_ready = 1'b0;
        dcnt = 0;
      end
      d_opcode   = cur.op;
      e_br_taken = cur.br;
      prev       = state;
    end
  end

  // Monitor: per-instruction observation, compared at retire or halt
  initial begin
    int         cyc, start, ndreq;
    logic       rfs, dws, prev_halt;
    logic [2:0] prev_state;
    exp_t       e;
    cyc = 0; start = 0; ndreq = 0; rfs = 1'b0; dws = 1'b0;
    prev_halt = 1'b0; prev_state = 3'd0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        prev_state = 3'd0; prev_halt = 1'b0;
        ndreq = 0; rfs = 1'b0; dws = 1'b0;
      end else begin
        if (state == 3'd1 && prev_state != 3'd1) begin
          start = cyc; ndreq = 0; rfs = 1'b0; dws = 1'b0;
        end
        if (dmem_req) ndreq++;
        if (rf_we)    rfs = 1'b1;
        if (dmem_we)  dws = 1'b1;
        if (f_pc_we || (halt && !prev_halt)) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_event_state", {61'd0, state}, 64'd0);
          end else begin
            e = sb_q.pop_front();
            chk("ev_kind",   {63'd0, halt}, e.kind);
            chk("ev_pc_sel", {63'd0, pc_sel}, {63'd0, e.pc_sel});
            chk("ev_rf_we",  {63'd0, rfs}, {63'd0, e.rf});
            chk("ev_dmem_we", {63'd0, dws}, {63'd0, e.dwe});
            chk("ev_dmem_req_cycles", ndreq, e.dreq);
            chk("ev_latency", cyc - start + 1, e.lat);
            chk("ev_err",    {63'd0, err}, {63'd0, e.err});
            chk("ev_retired", {60'd0, retired}, {60'd0, e.ret});
          end
        end
        prev_state = state;
        prev_halt  = halt;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    run   = 1'b0;
    sb_q.delete();
    prog_q.delete();
    model_ret = 4'd0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_last_exec(input int lim);
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (prog_q.size() == 0 && state == 3'd3) break;
    end
    chk("reach_last_execute", {61'd0, state}, 64'd3);
  endtask

  task automatic wait_halt(input int lim);
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (halt) break;
    end
    chk("reach_halt", {63'd0, halt}, 64'd1);
  endtask

  task automatic sticky_check(input logic er);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      run = ~run;
    end
    @(negedge clk);
    chk("halt_state", {61'd0, state}, 64'd6);
    chk("halt_sticky", {63'd0, halt}, 64'd1);
    chk("halt_err", {63'd0, err}, {63'd0, er});
    chk("halt_ctl_zero", {57'd0, imem_req, ir_we, f_pc_we, pc_sel, rf_we, dmem_req, dmem_we}, 64'd0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_trace[0] = 3'd1; exp_trace[1] = 3'd2; exp_trace[2] = 3'd3;
    exp_trace[3] = 3'd5; exp_trace[4] = 3'd1;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_state", {61'd0, state}, 64'd0);
    chk("rst_retired", {60'd0, retired}, 64'd0);
    chk("rst_halt", {63'd0, halt}, 64'd0);
    chk("rst_err", {63'd0, err}, 64'd0);
    chk("rst_ctl_zero", {57'd0, imem_req, ir_we, f_pc_we, pc_sel, rf_we, dmem_req, dmem_we}, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // Mixed program, run held until the last instruction's EXECUTE
    load(7'b0010011, 1'b0, 0, 0);  exp_ret(1'b0, 1'b1, 1'b0, 0, 4);   // ADDI
    load(7'b1100011, 1'b1, 0, 0);  exp_ret(1'b1, 1'b0, 1'b0, 0, 3);   // branch taken
    load(7'b1100011, 1'b0, 0, 0);  exp_ret(1'b0, 1'b0, 1'b0, 0, 3);   // branch not taken
    load(7'b0000011, 1'b0, 0, 3);  exp_ret(1'b0, 1'b1, 1'b0, 4, 8);   // load, 3 waits
    load(7'b0100011, 1'b0, 0, 0);  exp_ret(1'b0, 1'b0, 1'b1, 1, 4);   // store
    load(7'b1101111, 1'b0, 0, 0);  exp_ret(1'b1, 1'b1, 1'b0, 0, 4);   // JAL
    load(7'b1100111, 1'b0, 0, 0);  exp_ret(1'b1, 1'b1, 1'b0, 0, 4);   // JALR
    load(7'b0110111, 1'b0, 2, 0);  exp_ret(1'b0, 1'b1, 1'b0, 0, 6);   // LUI, 2 fetch waits
    load(7'b0010111, 1'b0, 0, 0);  exp_ret(1'b0, 1'b1, 1'b0, 0, 4);   // AUIPC
    load(7'b0110011, 1'b0, 15, 0); exp_ret(1'b0, 1'b1, 1'b0, 0, 19);  // OP, ready on 16th fetch cycle
    run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("state_trace", {61'd0, state}, {61'd0, exp_trace[i]});
    end
    wait_last_exec(200);
    run = 1'b0;
    repeat (3) @(negedge clk);
    chk("run_drop_idle", {61'd0, state}, 64'd0);
    chk("retired_after_10", {60'd0, retired}, 64'd10);
    chk("sb_drain_1", sb_q.size(), 64'd0);

    // Retire counter wrap with a 4-bit counter
    do_reset();
    for (int i = 0; i < 17; i++) begin
      load(7'b0010011, 1'b0, 0, 0);
      exp_ret(1'b0, 1'b1, 1'b0, 0, 4);
    end
    run = 1'b1;
    wait_last_exec(200);
    run = 1'b0;
    repeat (3) @(negedge clk);
    chk("retired_wrap", {60'd0, retired}, 64'd1);
    chk("sb_drain_2", sb_q.size(), 64'd0);

    // Illegal opcode
    do_reset();
    load(7'b1111111, 1'b0, 0, 0);
    exp_halt(1'b1, 3);
    run = 1'b1;
    wait_halt(20);
    sticky_check(1'b1);

    // SYSTEM opcode
    do_reset();
    load(7'b1110011, 1'b0, 0, 0);
    exp_halt(1'b0, 3);
    run = 1'b1;
    wait_halt(20);
    sticky_check(1'b0);

    // Fetch never answered
    do_reset();
    load(7'b0010011, 1'b0, -1, 0);
    exp_halt(1'b1, 17);
    run = 1'b1;
    wait_halt(40);
    chk("timeout_state", {61'd0, state}, 64'd6);
    chk("timeout_err", {63'd0, err}, 64'd1);

    // Asynchronous reset in the middle of a data access
    do_reset();
    load(7'b0000011, 1'b0, 0, -1);
    run = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (state == 3'd4) break;
    end
    chk("reach_memory", {61'd0, state}, 64'd4);
    #2 reset = 1'b0;
    run = 1'b0;
    #1;
    chk("midrst_state", {61'd0, state}, 64'd0);
    chk("midrst_ctl_zero", {57'd0, imem_req, ir_we, f_pc_we, pc_sel, rf_we, dmem_req, dmem_we}, 64'd0);
    chk("midrst_status", {62'd0, halt, err}, 64'd0);
    chk("midrst_retired", {60'd0, retired}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", {61'd0, state}, 64'd0);
    chk("sb_drain_end", sb_q.size(), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
